// File: rtl/dmem_sized.sv
// dmem_sized: word-organised data memory with RISC-V load/store sizes, a post-reset
// clear sweep and a 1-cycle registered response. Optional macro: DMEM_MISALIGN_TRAP_EN.
module dmem_sized #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDXW = $clog2(DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic TRAP_MISALIGN = 1'b1;
`else
  localparam logic TRAP_MISALIGN = 1'b0;
`endif

  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t          state_r, state_n;
  logic [IDXW-1:0] cnt_r;
  logic            ready_r;
  logic [31:0]     mem [DEPTH];

  logic [IDXW-1:0] idx_s;
  logic [1:0]      off_s;
  logic            accept_s, range_err_s, f3_err_s, mis_s, err_s;
  logic            wr_s, clr_s;
  logic [3:0]      be_s;
  logic [31:0]     wrep_s, word_s, shifted_s, ld_s;
  logic [7:0]      byte_s;
  logic [15:0]     half_s;

  assign req_ready = ready_r;

  // Next-state logic: the sweep ends after the last word is cleared.
  always_comb begin
    state_n = state_r;
    case (state_r)
      INIT: begin
        if (CLEAR_ON_RESET == 0) begin
          state_n = RUN;
        end else if (cnt_r == IDXW'(DEPTH - 1)) begin
          state_n = RUN;
        end else begin
          state_n = INIT;
        end
      end
      RUN:     state_n = RUN;
      default: state_n = INIT;
    endcase
  end

  // Request decode: lanes, replicated store data and error classification.
  always_comb begin
    idx_s       = req_addr[IDXW+1:2];
    off_s       = req_addr[1:0];
    accept_s    = req_valid && ready_r;
    range_err_s = |req_addr[ADDR_WIDTH-1:IDXW+2];
    f3_err_s    = 1'b0;
    mis_s       = 1'b0;
    be_s        = 4'b0000;
    wrep_s      = 32'd0;
    case (req_funct3)
      3'b000: begin
        be_s   = 4'b0001 << off_s;
        wrep_s = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        be_s   = off_s[1] ? 4'b1100 : 4'b0011;
        wrep_s = {2{req_wdata[15:0]}};
        mis_s  = off_s[0];
      end
      3'b010: begin
        be_s   = 4'b1111;
        wrep_s = req_wdata;
        mis_s  = (off_s != 2'b00);
      end
      3'b100:  f3_err_s = req_we;
      3'b101: begin
        f3_err_s = req_we;
        mis_s    = off_s[0];
      end
      default: f3_err_s = 1'b1;
    endcase
    err_s = range_err_s || f3_err_s || (TRAP_MISALIGN && mis_s);
    wr_s  = accept_s && req_we && !err_s;
    clr_s = (state_r == INIT) && (CLEAR_ON_RESET != 0);
  end

  // Load path: the addressed word is read combinationally and extended; the result is registered.
  always_comb begin
    word_s    = mem[idx_s];
    shifted_s = word_s >> {off_s, 3'b000};
    byte_s    = shifted_s[7:0];
    half_s    = off_s[1] ? word_s[31:16] : word_s[15:0];
    case (req_funct3)
      3'b000:  ld_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  ld_s = {{16{half_s[15]}}, half_s};
      3'b010:  ld_s = word_s;
      3'b100:  ld_s = {24'd0, byte_s};
      3'b101:  ld_s = {16'd0, half_s};
      default: ld_s = 32'd0;
    endcase
  end

  // Storage array: clear sweep has priority, otherwise byte-lane stores.
  always_ff @(posedge clk) begin
    if (clr_s) begin
      mem[cnt_r] <= 32'd0;
    end else if (wr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[idx_s][8*i +: 8] <= wrep_s[8*i +: 8];
        end
      end
    end
  end

  // Control state, sweep counter and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= INIT;
      cnt_r     <= '0;
      ready_r   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state_r   <= state_n;
      if (clr_s) begin
        cnt_r <= cnt_r + IDXW'(1);
      end
      ready_r   <= (state_n == RUN);
      rsp_valid <= accept_s;
      rsp_err   <= accept_s && err_s;
      rsp_rdata <= (accept_s && !err_s && !req_we) ? ld_s : 32'd0;
    end
  end

endmodule
